// File: rtl/sram_arb_pkg.sv
// Shared constants and the controller state type for the SRAM port arbiter.
package sram_arb_pkg;
  localparam int NPORT    = 3;
  localparam int PORT_IMG = 0;
  localparam int PORT_KEY = 1;
  localparam int PORT_WR  = 2;

  typedef enum logic [1:0] {IDLE, STROBE, RELEASE} state_t;
endpackage

// File: rtl/sram_arb_pick.sv
// Combinational 3-way picker: first requester found when searching upward
// from ptr (wrapping), returned one-hot.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [1:0]       ptr,
  output logic [NPORT-1:0] win,
  output logic             valid
);
  logic [NPORT-1:0] rot;
  logic [NPORT-1:0] pick;

  // rot[k] is the request from port (ptr+k) mod 3, so bit 0 has top priority
  always_comb begin
    case (ptr)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
  end

  always_comb begin
    pick = '0;
    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
  end

  always_comb begin
    case (ptr)
      2'd1:    win = {pick[1], pick[0], pick[2]};
      2'd2:    win = {pick[0], pick[2], pick[1]};
      default: win = pick;
    endcase
  end

  assign valid = |req;
endmodule

// File: rtl/sram_port_arbiter.sv
// Three-port arbiter/sequencer for one asynchronous 16-bit SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority 0>1>2.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        req,
  input  logic [NPORT-1:0]        req_we,
  input  logic [NPORT*ADDR_W-1:0] req_addr,
  input  logic [NPORT*DATA_W-1:0] req_wdata,
  output logic [NPORT-1:0]        gnt,
  output logic [NPORT-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [ADDR_W-1:0]       addressbus2,
  inout  wire  [DATA_W-1:0]       databus1,
  output logic                    ce,
  output logic                    oe,
  output logic                    we,
  output logic                    lsb,
  output logic                    msb
);
  state_t             state, state_nx;
  logic [2:0]         cnt;
  logic [NPORT-1:0]   port_q;
  logic               wr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               drive;
  logic [1:0]         ptr;
  logic [NPORT-1:0]   win;
  logic               win_vld;
  logic               take;
  logic               last;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;

  sram_arb_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_vld)
  );

`ifdef SRAM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= 2'd0;
    else if (take) ptr <= win[PORT_IMG] ? 2'(PORT_KEY) :
                          win[PORT_KEY] ? 2'(PORT_WR)  : 2'(PORT_IMG);
  end
`else
  assign ptr = 2'd0;
`endif

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (win[p]) begin
        sel_addr  = sel_addr  | req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata = sel_wdata | req_wdata[p*DATA_W +: DATA_W];
        sel_we    = sel_we    | req_we[p];
      end
    end
  end

  assign last = (cnt == 3'(WAIT_CYC));

  // RELEASE arbitrates like IDLE so back-to-back accesses skip the IDLE cycle
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx = STROBE;
          take     = 1'b1;
        end
      end
      STROBE: begin
        if (last) state_nx = RELEASE;
      end
      RELEASE: begin
        take     = win_vld;
        state_nx = win_vld ? STROBE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      port_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      addressbus2 <= '0;
      drive       <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      oe          <= 1'b1;
      we          <= 1'b1;
    end else begin
      state <= state_nx;
      gnt   <= '0;
      done  <= '0;
      if (take) begin
        port_q      <= win;
        wr_q        <= sel_we;
        addressbus2 <= sel_addr;
        if (sel_we) wdata_q <= sel_wdata;
        cnt         <= '0;
        gnt         <= win;
        oe          <= sel_we;
        we          <= ~sel_we;
        // a read chained after a write releases the bus on this same edge
        drive       <= sel_we;
      end else if (state == STROBE) begin
        if (last) begin
          oe   <= 1'b1;
          we   <= 1'b1;
          done <= port_q;
          if (!wr_q) rdata <= databus1;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (state == RELEASE) begin
        drive <= 1'b0;
      end
    end
  end

  assign databus1 = drive ? wdata_q : {DATA_W{1'bz}};
  assign busy     = (state != IDLE);
  assign ce       = 1'b0;
  assign lsb      = 1'b0;
  assign msb      = 1'b0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (WAIT_CYC=0 and WAIT_CYC=3 instances).
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam logic [15:0] PROBE = 16'h0F0F;

  logic        clk, reset;
  logic [2:0]  req, req_we, gnt, done;
  logic [53:0] req_addr;
  logic [47:0] req_wdata;
  logic [15:0] rdata;
  logic        busy, ce, oe, we, lsb, msb;
  logic [17:0] addressbus2;
  wire  [15:0] databus1;

  logic [2:0]  r3_req, r3_req_we, r3_gnt, r3_done;
  logic [53:0] r3_addr;
  logic [47:0] r3_wdata;
  logic [15:0] r3_rdata;
  logic        r3_busy, r3_ce, r3_oe, r3_we, r3_lsb, r3_msb;
  logic [17:0] r3_abus;
  wire  [15:0] r3_bus;

  logic [15:0] mem [0:255];
  logic        probe_en;
  int          checks, failures;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .addressbus2(addressbus2), .databus1(databus1), .ce(ce), .oe(oe), .we(we),
    .lsb(lsb), .msb(msb)
  );

  sram_port_arbiter #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .req(r3_req), .req_we(r3_req_we), .req_addr(r3_addr),
    .req_wdata(r3_wdata), .gnt(r3_gnt), .done(r3_done), .rdata(r3_rdata), .busy(r3_busy),
    .addressbus2(r3_abus), .databus1(r3_bus), .ce(r3_ce), .oe(r3_oe), .we(r3_we),
    .lsb(r3_lsb), .msb(r3_msb)
  );

  // SRAM models: drive on oe low, capture on the rising we edge
  assign databus1 = (!oe && we) ? mem[addressbus2[7:0]] : 16'hzzzz;
  assign databus1 = probe_en ? PROBE : 16'hzzzz;
  assign r3_bus   = !r3_oe ? 16'hC3C3 : 16'hzzzz;

  always @(posedge we) if (!reset) mem[addressbus2[7:0]] <= databus1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a lone probe driver reads back intact only if nothing else drives the bus
  task automatic check_hiz(input string name);
    probe_en = 1'b1;
    #1;
    checks++;
    if (databus1 !== PROBE) begin
      failures++;
      $display("FAIL %s bus_not_released got=%h want=%h", name, databus1, PROBE);
    end
    probe_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({gnt, done, busy, oe, we} !== 9'b000_000_0_11) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=%b", {gnt, done, busy, oe, we}, 9'b000_000_0_11);
    end
    checks++;
    if (rdata !== 16'h0 || addressbus2 !== 18'h0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h want=0/0", rdata, addressbus2);
    end
    checks++;
    if ({ce, lsb, msb} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ties got=%b want=000", {ce, lsb, msb});
    end
    check_hiz("reset");
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_single_read();
    req_addr  = {18'h0, 18'h0, 18'h00010};
    req_we    = 3'b000;
    req_wdata = {16'h0, 16'h0, 16'hFFFF};
    req       = 3'b001;
    tick();
    checks++;
    if ({gnt, done, oe, we, busy} !== 9'b001_000_0_1_1) begin
      failures++;
      $display("FAIL read_strobe got=%b want=%b", {gnt, done, oe, we, busy}, 9'b001_000_011);
    end
    checks++;
    if (addressbus2 !== 18'h00010 || databus1 !== 16'hA55A) begin
      failures++;
      $display("FAIL read_bus got=%h/%h want=00010/a55a", addressbus2, databus1);
    end
    req = 3'b000;
    tick();
    checks++;
    if ({gnt, done, oe, we, busy} !== 9'b000_001_1_1_1 || rdata !== 16'hA55A) begin
      failures++;
      $display("FAIL read_done got=%b rdata=%h want=%b rdata=a55a",
               {gnt, done, oe, we, busy}, rdata, 9'b000_001_111);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 3'b000 || rdata !== 16'hA55A) begin
      failures++;
      $display("FAIL read_idle got=busy%b done%b rdata=%h want=busy0 done000 rdata=a55a",
               busy, done, rdata);
    end
  endtask

  task automatic test_single_write();
    req_addr  = {18'h0C500, 18'h0, 18'h0};
    req_we    = 3'b100;
    req_wdata = {16'h1234, 16'h0, 16'h0};
    req       = 3'b100;
    tick();
    checks++;
    if ({gnt, oe, we} !== 5'b100_1_0 || databus1 !== 16'h1234 || addressbus2 !== 18'h0C500) begin
      failures++;
      $display("FAIL write_strobe got=%b bus=%h addr=%h want=10010 bus=1234 addr=0c500",
               {gnt, oe, we}, databus1, addressbus2);
    end
    req = 3'b000;
    tick();
    checks++;
    if ({done, oe, we} !== 5'b100_1_1 || databus1 !== 16'h1234 || addressbus2 !== 18'h0C500) begin
      failures++;
      $display("FAIL write_release got=%b bus=%h addr=%h want=10011 bus=1234 addr=0c500",
               {done, oe, we}, databus1, addressbus2);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || mem[0] !== 16'h1234 || rdata !== 16'hA55A) begin
      failures++;
      $display("FAIL write_after got=busy%b mem=%h rdata=%h want=busy0 mem=1234 rdata=a55a",
               busy, mem[0], rdata);
    end
    check_hiz("write_turnaround");
  endtask

  task automatic test_contention();
    int          exp_i [4];
    logic [15:0] val [3];
    logic [2:0]  eg;
`ifdef SRAM_ARB_RR_EN
    exp_i = '{PORT_IMG, PORT_KEY, PORT_WR, PORT_IMG};
`else
    exp_i = '{PORT_IMG, PORT_IMG, PORT_IMG, PORT_IMG};
`endif
    val       = '{16'hA55A, 16'h5AA5, 16'h1357};
    req_addr  = {18'h00040, 18'h00020, 18'h00010};
    req_we    = 3'b000;
    req       = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 1) begin
        eg = 3'b001 << exp_i[(k-1)/2];
        checks++;
        if (gnt !== eg || done !== 3'b000) begin
          failures++;
          $display("FAIL contend_gnt%0d got=%b/%b want=%b/000", k, gnt, done, eg);
        end
        if (k == 7) req = 3'b000;
      end else begin
        eg = 3'b001 << exp_i[k/2-1];
        checks++;
        if (done !== eg || gnt !== 3'b000 || rdata !== val[exp_i[k/2-1]]) begin
          failures++;
          $display("FAIL contend_done%0d got=%b/%b rdata=%h want=%b/000 rdata=%h",
                   k, done, gnt, rdata, eg, val[exp_i[k/2-1]]);
        end
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL contend_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_chain();
    // port 1 read, port 2 write, then port 0 read raised during the write
    req_addr  = {18'h00030, 18'h00020, 18'h00040};
    req_we    = 3'b100;
    req_wdata = {16'hBEEF, 16'h0, 16'h0};
    req       = 3'b110;
    tick();
    checks++;
    if ({gnt, oe, we, busy} !== 6'b010_0_1_1 || databus1 !== 16'h5AA5) begin
      failures++;
      $display("FAIL chain_rd_strobe got=%b bus=%h want=010011 bus=5aa5", {gnt, oe, we, busy}, databus1);
    end
    req = 3'b100;
    tick();
    checks++;
    if ({done, oe, we, busy} !== 6'b010_1_1_1 || rdata !== 16'h5AA5) begin
      failures++;
      $display("FAIL chain_rd_release got=%b rdata=%h want=010111 rdata=5aa5", {done, oe, we, busy}, rdata);
    end
    tick();
    checks++;
    if ({gnt, oe, we, busy} !== 6'b100_1_0_1 || databus1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL chain_wr_strobe got=%b bus=%h want=100101 bus=beef", {gnt, oe, we, busy}, databus1);
    end
    req = 3'b001;
    tick();
    checks++;
    if ({done, oe, we, busy} !== 6'b100_1_1_1 || databus1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL chain_wr_release got=%b bus=%h want=100111 bus=beef", {done, oe, we, busy}, databus1);
    end
    tick();
    checks++;
    if ({gnt, oe, we, busy} !== 6'b001_0_1_1 || databus1 !== 16'h1357) begin
      failures++;
      $display("FAIL chain_turnaround got=%b bus=%h want=001011 bus=1357", {gnt, oe, we, busy}, databus1);
    end
    req = 3'b000;
    tick();
    checks++;
    if (done !== 3'b001 || rdata !== 16'h1357 || mem[8'h30] !== 16'hBEEF) begin
      failures++;
      $display("FAIL chain_last got=%b rdata=%h mem=%h want=001 rdata=1357 mem=beef",
               done, rdata, mem[8'h30]);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL chain_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_wait_cyc();
    logic [7:0] exp_v;
    r3_addr   = {18'h0, 18'h00005, 18'h0};
    r3_req_we = 3'b000;
    r3_req    = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) r3_req = 3'b000;
      exp_v = {(k == 1) ? 3'b010 : 3'b000, (k == 5) ? 3'b010 : 3'b000, (k <= 4) ? 1'b0 : 1'b1, 1'b1};
      checks++;
      if ({r3_gnt, r3_done, r3_oe, r3_we} !== exp_v) begin
        failures++;
        $display("FAIL wait_cyc%0d got=%b want=%b", k, {r3_gnt, r3_done, r3_oe, r3_we}, exp_v);
      end
    end
    checks++;
    if (r3_rdata !== 16'hC3C3 || r3_busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_rdata got=%h busy%b want=c3c3 busy0", r3_rdata, r3_busy);
    end
  endtask

  task automatic test_reset_mid_write();
    req_addr  = {18'h00050, 18'h0, 18'h0};
    req_we    = 3'b100;
    req_wdata = {16'h6789, 16'h0, 16'h0};
    req       = 3'b100;
    tick();
    req = 3'b000;
    checks++;
    if (we !== 1'b0 || databus1 !== 16'h6789) begin
      failures++;
      $display("FAIL rst_mid_pre got=we%b bus=%h want=we0 bus=6789", we, databus1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({we, oe, busy, gnt, done} !== 9'b1_1_0_000_000) begin
      failures++;
      $display("FAIL rst_mid_async got=%b want=110000000", {we, oe, busy, gnt, done});
    end
    check_hiz("rst_mid");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done !== 3'b000 || busy !== 1'b0 || rdata !== 16'h0) begin
        failures++;
        $display("FAIL rst_mid_after%0d got=done%b busy%b rdata=%h want=done000 busy0 rdata=0",
                 k, done, busy, rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    probe_en = 1'b0;
    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    r3_req = '0; r3_req_we = '0; r3_addr = '0; r3_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[8'h10] = 16'hA55A;
    mem[8'h20] = 16'h5AA5;
    mem[8'h40] = 16'h1357;
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_chain();
    test_wait_cyc();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

- Shares the single external 16-bit asynchronous SRAM between three requesters in the image-encryption datapath:
  - port 0: image pixel reader;
  - port 1: chaotic address-table reader;
  - port 2: scrambled-result writer.
- Sequences every SRAM access (address, OE/WE strobes, bus turnaround).
- Returns read data and completion pulses, so stage controllers issue requests instead of driving SRAM pins directly.

## Interface
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYC, 0, extra strobe cycles per access (0–7) for slower SRAM parts
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  3  per-port access request, held until granted
- req_we  in  3  per-port direction: 1 write, 0 read
- req_addr  in  3*ADDR_W  per-port address, port n at bits [n*ADDR_W +: ADDR_W]
- req_wdata  in  3*DATA_W  per-port write data, same packing
- gnt  out  3  one-cycle grant pulse, one-hot
- done  out  3  one-cycle completion pulse, one-hot
- rdata  out  DATA_W  read data, valid in the done cycle and held until the next read completes
- busy  out  1  high whenever state is not IDLE
- addressbus2  out  ADDR_W  SRAM address
- databus1  inout  DATA_W  SRAM data bus
- ce, oe, we, lsb, msb  out  1  SRAM controls, all active-low

## Operation
- States: IDLE, STROBE, RELEASE.
- IDLE:
  - If any req bit is high, select winner w.
  - Latch req_addr/req_we/req_wdata of port w.
  - Go to STROBE and pulse gnt[w] in the first STROBE cycle.
- STROBE:
  - Lasts 1+WAIT_CYC cycles; counter is 3 bits.
  - addressbus2 = latched address.
  - Read: oe=0, databus1 hi-Z.
  - Write: we=0, databus1 driven with latched data.
  - On the last STROBE edge:
    - read: capture databus1 into rdata;
    - both: deassert oe/we;
    - go to RELEASE.
- RELEASE:
  - done[w]=1.
  - Write data stays driven here for hold time; address holds.
  - Arbitration runs here exactly as in IDLE. A pending req goes straight to STROBE; otherwise go to IDLE.
- Requester rules:
  - addr/we/wdata must stay stable while req is high and ungranted.
  - After gnt, the requester may drop req or present the next request with new fields.
- ce, lsb, msb are tied 0.
- req_wdata is ignored for reads.
- A simultaneous request from all three ports resolves to exactly one grant per arbitration.

## Timing
- Reset values (asynchronous):
  - state IDLE;
  - gnt=0, done=0, rdata=0, busy=0;
  - we=1, oe=1, addressbus2=0;
  - databus1 hi-Z;
  - priority pointer = 0.
- Reset during STROBE or RELEASE:
  - oe and we return high and the bus releases immediately;
  - no done pulse;
  - the aborted request is not retried.
- Latency, from the IDLE edge sampling req to the done cycle: 2+WAIT_CYC cycles.
- Back-to-back throughput: one access per 2+WAIT_CYC cycles (RELEASE→STROBE chaining).
- Bus turnaround: databus1 goes hi-Z in the first IDLE/STROBE cycle after a write's RELEASE. A write is never driven during an oe=0 cycle.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration.
  - After a grant to w, pointer = (w+1) mod 3.
  - Search starts at the pointer.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 > 1 > 2. The pointer register is not instantiated.

## Structure
- Package sram_arb_pkg holds:
  - NPORT=3;
  - port index constants PORT_IMG=0, PORT_KEY=1, PORT_WR=2;
  - state enum {IDLE, STROBE, RELEASE}.
- One sub-module, sram_arb_pick:
  - combinational 3-way picker, inputs req and start pointer;
  - outputs one-hot winner and valid;
  - pointer is tied to 0 when SRAM_ARB_RR_EN is undefined.

## Test plan
- Single read: port 0 reads addr 0x00010 with a SRAM model returning 0xA55A, WAIT_CYC=0. Expect gnt[0] next cycle, oe=0 for 1 cycle, done[0] one cycle later, rdata=0xA55A.
- Single write: port 2 writes 0x1234 to 0x0C500. Expect we=0 for 1 cycle, databus1=0x1234 through RELEASE, done[2], then bus hi-Z.
- Contention: all three req held from the same cycle.
  - With SRAM_ARB_RR_EN: grant order 0,1,2, then 0 again on re-request.
  - Without the macro, port 0 re-requesting continuously starves ports 1 and 2.
- Chaining: ports 1 and 2 each keep one request pending (port 1 a read, port 2 a write). Expect RELEASE→STROBE with no IDLE cycle, throughput of 2 cycles per access, and no oe=0 cycle overlapping a driven bus.
- WAIT_CYC=3: a read holds oe=0 for 4 cycles and done arrives 5 cycles after req sampling.
- Reset asserted in the middle of a write STROBE: we rises in the same cycle, databus1 goes hi-Z, no done, state is IDLE after reset release.
